// File: rtl/div_unit.sv
// Multi-cycle restoring radix-2 divider for DIV/DIVU: 34 cycles per divide (2 on divide-by-zero).
// result is {remainder, quotient} and holds from one DONE to the next.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 start,
  input  logic                 signed_div,
  input  logic                 annul,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 ready,
  output logic [2*WIDTH-1:0]   result,
  output logic [1:0]           state_dbg
);

  // Handshake: start is a level request honoured only in IDLE (annul wins);
  // ready is a one-cycle pulse, result stays valid until the next pulse.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0]   a_l, b_l;
  logic               sgn_l;
  logic               qneg, rneg;
  logic [WIDTH-1:0]   dvs;
  logic [2*WIDTH:0]   rq;
  logic [5:0]         cnt;

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH:0]   shifted;
  logic [WIDTH:0]     diff;
  logic [WIDTH-1:0]   q_fin, r_fin;

  assign a_mag   = (sgn_l && a_l[WIDTH-1]) ? (~a_l + 1'b1) : a_l;
  assign b_mag   = (sgn_l && b_l[WIDTH-1]) ? (~b_l + 1'b1) : b_l;
  assign shifted = {rq[2*WIDTH-1:0], 1'b0};
  // A set top bit means the trial subtraction went negative: restore.
  assign diff    = shifted[2*WIDTH:WIDTH] - {1'b0, dvs};
  assign q_fin   = qneg ? (~rq[WIDTH-1:0] + 1'b1) : rq[WIDTH-1:0];
  assign r_fin   = rneg ? (~rq[2*WIDTH-1:WIDTH] + 1'b1) : rq[2*WIDTH-1:WIDTH];

  assign busy      = (state == PREP) || (state == DIV);
  assign state_dbg = state;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start && !annul) state_nxt = PREP;
      PREP: begin
        if (annul)          state_nxt = IDLE;
        else if (b_l == '0) state_nxt = DONE;
        else                state_nxt = DIV;
      end
      DIV: begin
        if (annul)             state_nxt = IDLE;
        else if (cnt == 6'd31) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      a_l    <= '0;
      b_l    <= '0;
      sgn_l  <= 1'b0;
      qneg   <= 1'b0;
      rneg   <= 1'b0;
      dvs    <= '0;
      rq     <= '0;
      cnt    <= '0;
      ready  <= 1'b0;
      result <= '0;
    end else begin
      ready <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !annul) begin
            a_l   <= a;
            b_l   <= b;
            sgn_l <= signed_div;
          end
        end
        PREP: begin
          rq   <= {{(WIDTH+1){1'b0}}, a_mag};
          dvs  <= b_mag;
          qneg <= sgn_l & (a_l[WIDTH-1] ^ b_l[WIDTH-1]);
          rneg <= sgn_l & a_l[WIDTH-1];
          cnt  <= '0;
        end
        DIV: begin
          if (!annul) begin
            if (!diff[WIDTH]) rq <= {diff, shifted[WIDTH-1:1], 1'b1};
            else              rq <= shifted;
            cnt <= cnt + 6'd1;
          end
        end
        DONE: begin
          if (b_l == '0) result <= {a_l, {WIDTH{1'b1}}};
          else           result <= {r_fin, q_fin};
          ready <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
